// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : calc_pkg                                                     |
// | Description : Types shared by the 4-bit calculator blocks: operator codes, |
// |               the key sequencer FSM states and the key priority encoder.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package calc_pkg;

  // Operator codes exchanged with the arithmetic/display core.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_code_t;

  // Key sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_REL = 2'd2
  } seq_state_t;

  // Debounced key levels are active-low: all ones means nothing is pressed.
  localparam logic [3:0] c_KEYS_RELEASED = 4'b1111;

  // Lowest key index wins when several presses land in the same cycle.
  function automatic op_code_t f_prio_encode(input logic [3:0] i_press);
    op_code_t w_code;
    w_code = OP_ADD;
    if (i_press[0])      w_code = OP_ADD;
    else if (i_press[1]) w_code = OP_SUB;
    else if (i_press[2]) w_code = OP_MUL;
    else if (i_press[3]) w_code = OP_DIV;
    return w_code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_debounce                                                 |
// | Description : One push-button: 2-flop synchronizer followed by a counting  |
// |               debouncer. The debounced level only follows the synchronized |
// |               input after DEBOUNCE_CYCLES consecutive cycles of agreement. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk       in   1  clock, rising edge                                     |
// |   rst_n     in   1  asynchronous active-low reset                          |
// |   i_key     in   1  raw key level, asynchronous, active-low                |
// |   o_key_db  out  1  debounced key level, active-low                        |
// +----------------------------------------------------------------------------+
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_key_db
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic               r_sync1;
  logic               r_sync2;   // synchronized key level (kS)
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_db;

  // The counter tracks how long kS has disagreed with the debounced level.
  // The flip happens at DEBOUNCE_CYCLES-1, so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_db    <= 1'b1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  assign o_key_db = r_db;

endmodule
`default_nettype wire

// File: rtl/calc_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_key_sequencer                                           |
// | Description : Calculator input front end. Debounces the four operator keys,|
// |               turns a press into a single command carrying the operator    |
// |               and the switch operands, presents it on a valid/ready        |
// |               handshake and rearms once every key is released.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   CLOCK_50  in   1  system clock, rising edge                              |
// |   RESET_N   in   1  asynchronous active-low reset                          |
// |   SW        in   8  SW[3:0] operand A, SW[7:4] operand B (asynchronous)    |
// |   KEY       in   4  operator keys, active-low: add, sub, mul, div          |
// |   op_valid  out  1  command presented                                      |
// |   op_ready  in   1  consumer accepts the command                           |
// |   op_code   out  2  0 ADD, 1 SUB, 2 MUL, 3 DIV                             |
// |   op_a      out  4  operand A latched at the press                         |
// |   op_b      out  4  operand B latched at the press                         |
// |   key_db    out  4  debounced key levels, active-low                       |
// +----------------------------------------------------------------------------+
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] SW,
  input  logic [3:0] KEY,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [1:0] op_code,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] key_db
);

  logic [3:0] w_key_db;
  logic [7:0] r_sw_meta;
  logic [7:0] r_sw_sync;      // synchronized switches (swS)
  logic [3:0] r_key_db_q;     // previous debounced levels for edge detect
  logic [3:0] r_press;        // one-cycle press pulses, one per key

  seq_state_t r_state;
  logic       r_op_valid;
  op_code_t   r_op_code;
  logic [3:0] r_op_a;
  logic [3:0] r_op_b;

  // Per-key synchronizer and debouncer.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .i_key    (KEY[gi]),
        .o_key_db (w_key_db[gi])
      );
    end
  endgenerate

  // Switch synchronizer and press detection. A press is a debounced 1->0
  // transition; releases produce nothing.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sw_meta  <= 8'h00;
      r_sw_sync  <= 8'h00;
      r_key_db_q <= c_KEYS_RELEASED;
      r_press    <= 4'b0000;
    end else begin
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
      r_key_db_q <= w_key_db;
      r_press    <= r_key_db_q & ~w_key_db;
    end
  end

  // Command FSM. Presses outside IDLE are dropped, so holding one key and
  // pressing another never produces a second command.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_IDLE;
      r_op_valid <= 1'b0;
      r_op_code  <= OP_ADD;
      r_op_a     <= 4'h0;
      r_op_b     <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_press) begin
            r_op_code  <= f_prio_encode(r_press);
            r_op_a     <= r_sw_sync[3:0];
            r_op_b     <= r_sw_sync[7:4];
            r_op_valid <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Payload stays frozen until the consumer takes it.
          if (op_ready) begin
            r_op_valid <= 1'b0;
            r_state    <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (w_key_db == c_KEYS_RELEASED) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_op_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_valid = r_op_valid;
  assign op_code  = r_op_code;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign key_db   = w_key_db;

endmodule
`default_nettype wire
